// File: rtl/display_page_controller.sv
// Picks which 16-bit debug value the four-digit display shows: button/auto page
// stepping, periodic tear-free snapshots and a timed priority override.
module display_page_controller #(
  parameter int NUM_PAGES       = 4,
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int ROTATE_CYCLES   = 200_000_000,
  parameter int SNAPSHOT_CYCLES = 10_000_000,
  parameter int OVR_HOLD_CYCLES = 100_000_000
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic [15:0]                  page_val [NUM_PAGES],
  input  logic                         btn_next,
  input  logic                         auto_en,
  input  logic                         ovr_req,
  input  logic [15:0]                  ovr_val,
  output logic                         ovr_ack,
  output logic                         ovr_active,
  output logic [$clog2(NUM_PAGES)-1:0] page_idx,
  output logic [3:0]                   dig [4]
);

  localparam int PW     = $clog2(NUM_PAGES);
  localparam int DB_W   = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int ROT_W  = (ROTATE_CYCLES > 2)   ? $clog2(ROTATE_CYCLES)   : 1;
  localparam int SNAP_W = (SNAPSHOT_CYCLES > 2) ? $clog2(SNAPSHOT_CYCLES) : 1;
  localparam int HOLD_W = (OVR_HOLD_CYCLES > 2) ? $clog2(OVR_HOLD_CYCLES) : 1;

  localparam logic [DB_W-1:0]   DB_MAX    = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [ROT_W-1:0]  ROT_MAX   = ROT_W'(ROTATE_CYCLES - 1);
  localparam logic [SNAP_W-1:0] SNAP_MAX  = SNAP_W'(SNAPSHOT_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(OVR_HOLD_CYCLES - 1);
  localparam logic [PW-1:0]     PAGE_LAST = PW'(NUM_PAGES - 1);

  typedef enum logic {
    ST_NORMAL   = 1'b0,
    ST_OVERRIDE = 1'b1
  } state_t;

  state_t            r_state;
  state_t            w_state_next;
  logic              r_sync1;
  logic              r_sync2;
  logic              r_db_level;
  logic              r_db_level_d;
  logic [DB_W-1:0]   r_db_cnt;
  logic [ROT_W-1:0]  r_rot_cnt;
  logic [SNAP_W-1:0] r_snap_cnt;
  logic [HOLD_W-1:0] r_hold_cnt;
  logic [PW-1:0]     r_page;
  logic [15:0]       r_disp;
  logic              r_ack;
  logic              r_force_refresh;

  logic w_step;
  logic w_rot;
  logic w_hold_done;
  logic w_refresh;
  logic w_accept;
  logic w_exit;
  logic w_advance;

  // Button path: two-flop synchronizer, then a level must persist for the
  // full debounce window before it is believed.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_sync1      <= 1'b0;
      r_sync2      <= 1'b0;
      r_db_level   <= 1'b0;
      r_db_level_d <= 1'b0;
      r_db_cnt     <= '0;
    end else begin
      r_sync1      <= btn_next;
      r_sync2      <= r_sync1;
      r_db_level_d <= r_db_level;
      if (r_sync2 == r_db_level) begin
        r_db_cnt <= '0;
      end else if (r_db_cnt == DB_MAX) begin
        r_db_level <= r_sync2;
        r_db_cnt   <= '0;
      end else begin
        r_db_cnt <= r_db_cnt + 1'b1;
      end
    end
  end

  assign w_step      = r_db_level & ~r_db_level_d;
  assign w_rot       = (r_state == ST_NORMAL) & auto_en & (r_rot_cnt == ROT_MAX);
  assign w_hold_done = (r_hold_cnt == HOLD_MAX);
  assign w_refresh   = (r_snap_cnt == SNAP_MAX) | r_force_refresh;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= ST_NORMAL;
    end else begin
      r_state <= w_state_next;
    end
  end

  // An override request always wins over a same-cycle step or rotation.
  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_exit       = 1'b0;
    w_advance    = 1'b0;
    case (r_state)
      ST_NORMAL: begin
        if (ovr_req) begin
          w_accept     = 1'b1;
          w_state_next = ST_OVERRIDE;
        end else if (w_step || w_rot) begin
          w_advance = 1'b1;
        end
      end
      ST_OVERRIDE: begin
        if (ovr_req) begin
          w_accept = 1'b1;
        end else if (w_step || w_hold_done) begin
          w_exit       = 1'b1;
          w_state_next = ST_NORMAL;
        end
      end
      default: w_state_next = ST_NORMAL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_rot_cnt       <= '0;
      r_snap_cnt      <= '0;
      r_hold_cnt      <= '0;
      r_page          <= '0;
      r_disp          <= '0;
      r_ack           <= 1'b0;
      r_force_refresh <= 1'b0;
    end else begin
      if ((r_state == ST_OVERRIDE) || w_accept || !auto_en || w_step || w_rot) begin
        r_rot_cnt <= '0;
      end else begin
        r_rot_cnt <= r_rot_cnt + 1'b1;
      end

      if (r_snap_cnt == SNAP_MAX) begin
        r_snap_cnt <= '0;
      end else begin
        r_snap_cnt <= r_snap_cnt + 1'b1;
      end

      if (w_accept || (r_state != ST_OVERRIDE) || w_exit) begin
        r_hold_cnt <= '0;
      end else begin
        r_hold_cnt <= r_hold_cnt + 1'b1;
      end

      if (w_advance) begin
        r_page <= (r_page == PAGE_LAST) ? '0 : r_page + 1'b1;
      end

      // Whole-word capture so the four digits always come from one sample.
      if (w_accept) begin
        r_disp <= ovr_val;
      end else if ((r_state == ST_NORMAL) && w_refresh) begin
        r_disp <= page_val[r_page];
      end

      r_ack           <= w_accept;
      r_force_refresh <= w_advance | w_exit;
    end
  end

  assign ovr_ack    = r_ack;
  assign ovr_active = (r_state == ST_OVERRIDE);
  assign page_idx   = r_page;

  for (genvar gi = 0; gi < 4; gi++) begin : g_dig
    assign dig[gi] = r_disp[4*gi +: 4];
  end

endmodule

// File: tb/tb_display_page_controller.sv
// Checks display_page_controller against a timestamp-based reference model
// using directed scenarios followed by randomized stimulus.
module tb_display_page_controller;

  localparam int NP   = 3;
  localparam int DB   = 4;
  localparam int ROT  = 50;
  localparam int SNAP = 20;
  localparam int HOLD = 30;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [15:0] page_val [NP];
  logic        btn_next = 1'b0;
  logic        auto_en = 1'b0;
  logic        ovr_req = 1'b0;
  logic [15:0] ovr_val = 16'h0000;
  logic        ovr_ack;
  logic        ovr_active;
  logic [1:0]  page_idx;
  logic [3:0]  dig [4];
  logic [15:0] w_dig;

  always #5 clk = ~clk;

  display_page_controller #(
    .NUM_PAGES      (NP),
    .DEBOUNCE_CYCLES(DB),
    .ROTATE_CYCLES  (ROT),
    .SNAPSHOT_CYCLES(SNAP),
    .OVR_HOLD_CYCLES(HOLD)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .page_val  (page_val),
    .btn_next  (btn_next),
    .auto_en   (auto_en),
    .ovr_req   (ovr_req),
    .ovr_val   (ovr_val),
    .ovr_ack   (ovr_ack),
    .ovr_active(ovr_active),
    .page_idx  (page_idx),
    .dig       (dig)
  );

  assign w_dig = {dig[3], dig[2], dig[1], dig[0]};

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
  endtask

  // Reference model: events are scheduled by absolute edge number since reset.
  int          m_t;
  int          m_page;
  int          m_rot_due;
  int          m_hold_due;
  bit          m_ovr;
  bit          m_ack;
  bit          m_force;
  bit          m_lvl;
  bit          m_step_pend;
  logic [15:0] m_disp;
  bit          b_hist[$];

  function automatic void model_reset();
    m_t         = 0;
    m_page      = 0;
    m_rot_due   = ROT;
    m_hold_due  = 0;
    m_ovr       = 1'b0;
    m_ack       = 1'b0;
    m_force     = 1'b0;
    m_lvl       = 1'b0;
    m_step_pend = 1'b0;
    m_disp      = 16'h0000;
    b_hist.delete();
    for (int i = 0; i < DB + 2; i++) b_hist.push_back(1'b0);
  endfunction

  task automatic model_edge();
    bit step, rot, refresh, accept, exit_ovr, adv, ovr_next, all_diff, new_lvl;
    int n;
    if (!reset_n) begin
      model_reset();
      return;
    end
    m_t++;
    step     = m_step_pend;
    rot      = !m_ovr && auto_en && (m_t == m_rot_due);
    refresh  = ((m_t % SNAP) == 0) || m_force;
    accept   = ovr_req;
    exit_ovr = m_ovr && !ovr_req && (step || (m_t == m_hold_due));
    adv      = !m_ovr && !ovr_req && (step || rot);
    if (accept) m_disp = ovr_val;
    else if (!m_ovr && refresh) m_disp = page_val[m_page];
    if (adv) m_page = (m_page + 1) % NP;
    m_ack   = accept;
    m_force = adv || exit_ovr;
    if (accept) m_hold_due = m_t + HOLD;
    ovr_next = accept || (m_ovr && !exit_ovr);
    if (m_ovr || ovr_next || !auto_en || step || rot) m_rot_due = m_t + ROT;
    m_ovr = ovr_next;
    // Button: the level seen by the debouncer lags the pin by two edges and
    // flips once DB consecutive samples disagree with the accepted level.
    b_hist.push_back(btn_next);
    n = b_hist.size();
    all_diff = 1'b1;
    for (int k = 0; k < DB; k++) if (b_hist[n-3-k] == m_lvl) all_diff = 1'b0;
    new_lvl     = all_diff ? !m_lvl : m_lvl;
    m_step_pend = new_lvl && !m_lvl;
    m_lvl       = new_lvl;
    void'(b_hist.pop_front());
  endtask

  task automatic tick();
    model_edge();
    @(negedge clk);
    check_eq("page_idx", 32'(page_idx), 32'(m_page));
    check_eq("dig", 32'(w_dig), 32'(m_disp));
    check_eq("ovr_active", 32'(ovr_active), 32'(m_ovr));
    check_eq("ovr_ack", 32'(ovr_ack), 32'(m_ack));
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wait_step(input string tag);
    bit found;
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      if (m_step_pend) found = 1'b1;
      else tick();
    end
    check_eq(tag, 32'(found), 32'd1);
  endtask

  task automatic press(input int hi, input int lo);
    $display("[%0t] press btn_next for %0d cycles", $time, hi);
    btn_next = 1'b1;
    ticks(hi);
    btn_next = 1'b0;
    ticks(lo);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   page_before;
    bit   aligned;
    int   btn_left;
    int   burst;
    page_val[0] = 16'h1234;
    page_val[1] = 16'hABCD;
    page_val[2] = 16'h00FF;
    model_reset();

    $display("[%0t] reset", $time);
    reset_n = 1'b0;
    ticks(2);
    reset_n = 1'b1;
    ticks(25);
    check_eq("first_refresh_dig", 32'(w_dig), 32'h1234);
    check_eq("first_refresh_page", 32'(page_idx), 32'd0);

    $display("[%0t] glitch then long press", $time);
    btn_next = 1'b1; ticks(2);
    btn_next = 1'b0; ticks(2);
    press(10, 12);
    check_eq("after_press_page", 32'(page_idx), 32'd1);
    check_eq("after_press_dig", 32'(w_dig), 32'hABCD);
    press(8, 10);
    press(7, 10);
    check_eq("wrap_page", 32'(page_idx), 32'd0);
    press(9, 10);

    $display("[%0t] auto rotate idle", $time);
    auto_en = 1'b1;
    ticks(120);
    aligned = 1'b0;
    for (int i = 0; i < 200 && !aligned; i++) begin
      if (m_t + 1 == m_rot_due - 6) aligned = 1'b1;
      else tick();
    end
    check_eq("rot_align", 32'(aligned), 32'd1);
    $display("[%0t] step coincident with rotate", $time);
    page_before = int'(page_idx);
    press(10, 0);
    check_eq("step_rot_single", 32'(page_idx), 32'((page_before + 1) % NP));
    ticks(110);

    $display("[%0t] page value change mid-period", $time);
    auto_en = 1'b0;
    ticks(3);
    while ((m_t % SNAP) != 7) tick();
    page_val[m_page] = 16'h5555;
    ticks(30);

    $display("[%0t] override with coincident step", $time);
    page_before = int'(page_idx);
    btn_next = 1'b1;
    wait_step("ovr_step_wait");
    ovr_req = 1'b1;
    ovr_val = 16'hDEAD;
    tick();
    ovr_req = 1'b0;
    btn_next = 1'b0;
    check_eq("ovr_ack_pulse", 32'(ovr_ack), 32'd1);
    check_eq("ovr_dig", 32'(w_dig), 32'hDEAD);
    check_eq("ovr_page_frozen", 32'(page_idx), 32'(page_before));
    ticks(29);
    check_eq("ovr_still_active", 32'(ovr_active), 32'd1);
    tick();
    check_eq("ovr_timeout", 32'(ovr_active), 32'd0);
    tick();
    check_eq("ovr_exit_refresh", 32'(w_dig), 32'(page_val[page_before]));
    ticks(10);

    $display("[%0t] override dismissed by step", $time);
    ovr_req = 1'b1;
    ovr_val = 16'hBEEF;
    tick();
    ovr_req = 1'b0;
    ticks(4);
    page_before = int'(page_idx);
    btn_next = 1'b1;
    wait_step("dismiss_step_wait");
    tick();
    check_eq("dismiss_exit", 32'(ovr_active), 32'd0);
    check_eq("dismiss_page", 32'(page_idx), 32'(page_before));
    btn_next = 1'b0;
    ticks(12);

    $display("[%0t] override re-request at final hold cycle", $time);
    ovr_req = 1'b1;
    ovr_val = 16'hC0DE;
    tick();
    ovr_req = 1'b0;
    while (m_t + 1 != m_hold_due) tick();
    ovr_req = 1'b1;
    ovr_val = 16'hF00D;
    tick();
    ovr_req = 1'b0;
    check_eq("reack_pulse", 32'(ovr_ack), 32'd1);
    check_eq("reack_dig", 32'(w_dig), 32'hF00D);
    ticks(15);
    check_eq("reack_active", 32'(ovr_active), 32'd1);
    $display("[%0t] reset during override", $time);
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    check_eq("rst_dig", 32'(w_dig), 32'h0000);
    check_eq("rst_active", 32'(ovr_active), 32'd0);
    check_eq("rst_page", 32'(page_idx), 32'd0);

    $display("[%0t] randomized traffic", $time);
    auto_en  = 1'b1;
    btn_left = 0;
    burst    = 0;
    for (int c = 0; c < 1500; c++) begin
      if (burst == 0 && $urandom_range(0, 299) == 0) burst = $urandom_range(5, 40);
      ovr_req = (burst > 0) || ($urandom_range(0, 99) < 2);
      if (burst > 0) burst--;
      ovr_val = 16'($urandom);
      if (btn_left == 0) begin
        btn_next = ~btn_next;
        btn_left = btn_next ? $urandom_range(1, 12) : $urandom_range(1, 20);
      end else begin
        btn_left--;
      end
      if ($urandom_range(0, 199) == 0) auto_en = ~auto_en;
      if ($urandom_range(0, 49) == 0) page_val[$urandom_range(0, NP-1)] = 16'($urandom);
      reset_n = ($urandom_range(0, 999) != 0);
      tick();
    end
    reset_n = 1'b1;
    ovr_req = 1'b0;
    btn_next = 1'b0;
    ticks(5);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
